sc_reg_bank: RTL and testbench

//  Parametrised bank of NUM_REGS datapath registers: one write/modify port, two async read ports.

---
 rtl/sc_reg_pkg.sv | 9 +
 rtl/sc_reg_cell.sv | 49 ++++
 rtl/sc_reg_bank.sv | 102 ++++++++++
 tb/tb_sc_reg_bank.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_reg_pkg.sv
// Shared op encodings for the datapath register bank.
// HOLD/LOAD/INC/CLEAR cover all four codes of the 2-bit op field.
package sc_reg_pkg;
   localparam int         OP_WIDTH = 2;
   localparam logic [1:0] OP_HOLD  = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_INC   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;
endpackage

// File: rtl/sc_reg_cell.sv
// One bank register, negedge-updated; o_next is the value an op would produce this cycle.
// FIXED cells are a constant: no flop, inputs ignored.
module sc_reg_cell
   import sc_reg_pkg::*;
#(
   parameter int             W     = 32,
   parameter bit             FIXED = 1'b0,
   parameter logic [W-1:0]   INIT  = '0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_sel,
   input  logic [OP_WIDTH-1:0] i_op,
   input  logic [W-1:0]        i_data,
   output logic [W-1:0]        o_value,
   output logic [W-1:0]        o_next
);

   generate
      if (FIXED) begin : g_fixed
         logic w_unused;
         assign w_unused = ^{i_clk, i_rst, i_sel, i_op, i_data};
         assign o_value  = INIT;
         assign o_next   = INIT;
      end else begin : g_flop
         logic [W-1:0] r_value;

         always_comb begin
            o_next = r_value;
            case (i_op)
               OP_LOAD:  o_next = i_data;
               OP_INC:   o_next = r_value + 1'b1;
               OP_CLEAR: o_next = '0;
               default:  o_next = r_value;
            endcase
         end

         always_ff @(negedge i_clk) begin
            if (i_rst)
               r_value <= INIT;
            else if (i_sel)
               r_value <= o_next;
         end

         assign o_value = r_value;
      end
   endgenerate

endmodule

// File: rtl/sc_reg_bank.sv
// Register bank: one negedge write/modify port, two combinational read ports.
// Writes to FIXED or nonexistent registers are dropped and flagged on WriteErr.
module sc_reg_bank
   import sc_reg_pkg::*;
#(
   parameter int                                DATAWIDTH_BUS = 32,
   parameter int                                NUM_REGS      = 8,
   parameter int                                ADDR_WIDTH    = 3,
   parameter logic [NUM_REGS-1:0]               FIXED_MASK    = 8'b0000_0001,
   parameter logic [NUM_REGS*DATAWIDTH_BUS-1:0] INIT_VALUES   = '0
) (
   input  logic                     SC_RegBANK_CLOCK_50,
   input  logic                     SC_RegBANK_Reset_InHigh,
   input  logic [ADDR_WIDTH-1:0]    SC_RegBANK_WrAddr_In,
   input  logic [OP_WIDTH-1:0]      SC_RegBANK_Op_In,
   input  logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUS_In,
   input  logic [ADDR_WIDTH-1:0]    SC_RegBANK_RdAddrA_In,
   input  logic [ADDR_WIDTH-1:0]    SC_RegBANK_RdAddrB_In,
   output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUSA_Out,
   output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUSB_Out,
   output logic                     SC_RegBANK_WriteErr_Out,
   output logic                     SC_RegBANK_Zero_Out
);

   localparam int W = DATAWIDTH_BUS;

   logic [W-1:0] w_vals [NUM_REGS];
   logic [W-1:0] w_nexts[NUM_REGS];
   logic         w_hit;
   logic         w_fixed;
   logic         w_legal;
   logic [W-1:0] w_sel_next;
   logic [W-1:0] w_rd_a;
   logic [W-1:0] w_rd_b;
   logic         r_write_err;
   logic         r_zero;

   // Hit is decoded per register, so an address >= NUM_REGS simply never matches.
   always_comb begin
      w_hit      = 1'b0;
      w_fixed    = 1'b0;
      w_sel_next = '0;
      w_rd_a     = '0;
      w_rd_b     = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (SC_RegBANK_WrAddr_In == ADDR_WIDTH'(i)) begin
            w_hit      = 1'b1;
            w_fixed    = FIXED_MASK[i];
            w_sel_next = w_nexts[i];
         end
         if (SC_RegBANK_RdAddrA_In == ADDR_WIDTH'(i))
            w_rd_a = w_vals[i];
         if (SC_RegBANK_RdAddrB_In == ADDR_WIDTH'(i))
            w_rd_b = w_vals[i];
      end
   end

   assign w_legal = w_hit && !w_fixed;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_cell
         logic w_sel;
         assign w_sel = w_legal && (SC_RegBANK_Op_In != OP_HOLD) &&
                        (SC_RegBANK_WrAddr_In == ADDR_WIDTH'(gi));

         sc_reg_cell #(
            .W     (W),
            .FIXED (FIXED_MASK[gi]),
            .INIT  (INIT_VALUES[gi*W +: W])
         ) u_cell (
            .i_clk   (SC_RegBANK_CLOCK_50),
            .i_rst   (SC_RegBANK_Reset_InHigh),
            .i_sel   (w_sel),
            .i_op    (SC_RegBANK_Op_In),
            .i_data  (SC_RegBANK_DataBUS_In),
            .o_value (w_vals[gi]),
            .o_next  (w_nexts[gi])
         );
      end
   endgenerate

   always_ff @(negedge SC_RegBANK_CLOCK_50) begin
      if (SC_RegBANK_Reset_InHigh) begin
         r_write_err <= 1'b0;
         r_zero      <= 1'b0;
      end else if (SC_RegBANK_Op_In == OP_HOLD) begin
         r_write_err <= 1'b0;
      end else if (!w_legal) begin
         r_write_err <= 1'b1;
      end else begin
         r_write_err <= 1'b0;
         r_zero      <= (w_sel_next == '0);
      end
   end

   assign SC_RegBANK_DataBUSA_Out = w_rd_a;
   assign SC_RegBANK_DataBUSB_Out = w_rd_b;
   assign SC_RegBANK_WriteErr_Out = r_write_err;
   assign SC_RegBANK_Zero_Out     = r_zero;

endmodule

// File: tb/tb_sc_reg_bank.sv
// Bench for sc_reg_bank: a default 8-register bank and a 6-register bank (reg5 init 0xCAFE)
// share one directed stimulus stream and are checked against an array model every posedge.
module tb_sc_reg_bank;
   localparam logic [1:0] HOLD = 2'b00, LOAD = 2'b01, INC = 2'b10, CLR = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  op;
   logic [2:0]  wa, ra, rb;
   logic [31:0] d;
   logic [31:0] a0, b0, a1, b1;
   logic        err0, z0, err1, z1;

   int n_total = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sc_reg_bank u_dut0 (
      .SC_RegBANK_CLOCK_50     (clk),
      .SC_RegBANK_Reset_InHigh (rst),
      .SC_RegBANK_WrAddr_In    (wa),
      .SC_RegBANK_Op_In        (op),
      .SC_RegBANK_DataBUS_In   (d),
      .SC_RegBANK_RdAddrA_In   (ra),
      .SC_RegBANK_RdAddrB_In   (rb),
      .SC_RegBANK_DataBUSA_Out (a0),
      .SC_RegBANK_DataBUSB_Out (b0),
      .SC_RegBANK_WriteErr_Out (err0),
      .SC_RegBANK_Zero_Out     (z0)
   );

   sc_reg_bank #(
      .NUM_REGS    (6),
      .FIXED_MASK  (6'b000001),
      .INIT_VALUES ({32'h0000_CAFE, 160'h0})
   ) u_dut1 (
      .SC_RegBANK_CLOCK_50     (clk),
      .SC_RegBANK_Reset_InHigh (rst),
      .SC_RegBANK_WrAddr_In    (wa),
      .SC_RegBANK_Op_In        (op),
      .SC_RegBANK_DataBUS_In   (d),
      .SC_RegBANK_RdAddrA_In   (ra),
      .SC_RegBANK_RdAddrB_In   (rb),
      .SC_RegBANK_DataBUSA_Out (a1),
      .SC_RegBANK_DataBUSB_Out (b1),
      .SC_RegBANK_WriteErr_Out (err1),
      .SC_RegBANK_Zero_Out     (z1)
   );

   // ---------------- behavioural model ----------------
   logic [31:0] mreg [2][8];
   logic        merr [2];
   logic        mzero[2];
   bit          mok = 1'b0;

   function automatic int nregs(input int k);
      return (k == 1) ? 6 : 8;
   endfunction

   function automatic logic [31:0] init_of(input int k, input int i);
      return (k == 1 && i == 5) ? 32'h0000_CAFE : 32'h0;
   endfunction

   function automatic logic [31:0] mread(input int k, input logic [2:0] addr);
      return (int'(addr) < nregs(k)) ? mreg[k][addr] : 32'h0;
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int i = 0; i < 8; i++) mreg[k][i] = init_of(k, i);
            merr[k]  = 1'b0;
            mzero[k] = 1'b0;
         end else if (op == HOLD) begin
            merr[k] = 1'b0;
         end else if (int'(wa) >= nregs(k) || wa == 3'd0) begin
            merr[k] = 1'b1;
         end else begin
            case (op)
               LOAD:    mreg[k][wa] = d;
               INC:     mreg[k][wa] = mreg[k][wa] + 32'd1;
               default: mreg[k][wa] = 32'h0;
            endcase
            merr[k]  = 1'b0;
            mzero[k] = (mreg[k][wa] == 32'h0);
         end
      end
      if (rst) mok = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: outputs are stable at posedge (updates on negedge, inputs move at posedge+1).
   always @(posedge clk) begin
      if (mok) begin
         chk("d0_rdA", a0, mread(0, ra));
         chk("d0_rdB", b0, mread(0, rb));
         chk("d0_err", {31'b0, err0}, {31'b0, merr[0]});
         chk("d0_zero", {31'b0, z0}, {31'b0, mzero[0]});
         chk("d1_rdA", a1, mread(1, ra));
         chk("d1_rdB", b1, mread(1, rb));
         chk("d1_err", {31'b0, err1}, {31'b0, merr[1]});
         chk("d1_zero", {31'b0, z1}, {31'b0, mzero[1]});
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(input logic r, input logic [1:0] o, input logic [2:0] a,
                        input logic [31:0] dd, input logic [2:0] xa, input logic [2:0] xb);
      @(posedge clk);
      #1;
      rst = r; op = o; wa = a; d = dd; ra = xa; rb = xb;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; op = HOLD; wa = 3'd0; d = 32'h0; ra = 3'd0; rb = 3'd5;
      step();
      chk("rst_A", a0, 32'h0);
      chk("rst_B", b0, 32'h0);
      chk("rst_err", {31'b0, err0}, 32'h0);
      chk("rst_zero", {31'b0, z0}, 32'h0);
      chk("rst_init_cafe", b1, 32'h0000_CAFE);

      drive(1'b0, LOAD, 3'd3, 32'h1234_5678, 3'd3, 3'd5);
      chk("load_old_value", a0, 32'h0);
      step();
      chk("load_new_value", a0, 32'h1234_5678);

      drive(1'b0, LOAD, 3'd2, 32'hFFFF_FFFF, 3'd2, 3'd3);
      step();
      drive(1'b0, INC, 3'd2, 32'h0, 3'd2, 3'd2);
      step();
      chk("inc_wrap", a0, 32'h0);
      chk("inc_wrap_zero", {31'b0, z0}, 32'h1);
      chk("same_addr_B", b0, 32'h0);
      drive(1'b0, INC, 3'd2, 32'h0, 3'd2, 3'd3);
      step();
      chk("inc_one", a0, 32'h1);
      chk("inc_one_zero", {31'b0, z0}, 32'h0);
      chk("reg3_kept", b0, 32'h1234_5678);

      drive(1'b0, LOAD, 3'd0, 32'h0000_00AA, 3'd0, 3'd0);
      step();
      chk("fixed_unchanged", a0, 32'h0);
      chk("fixed_err", {31'b0, err0}, 32'h1);
      drive(1'b0, HOLD, 3'd0, 32'h0, 3'd0, 3'd0);
      step();
      chk("hold_clears_err", {31'b0, err0}, 32'h0);

      drive(1'b0, LOAD, 3'd7, 32'h0000_0055, 3'd7, 3'd7);
      step();
      chk("d0_reg7_loaded", a0, 32'h0000_0055);
      chk("d0_reg7_noerr", {31'b0, err0}, 32'h0);
      chk("d1_oor_err", {31'b0, err1}, 32'h1);
      chk("d1_oor_read", a1, 32'h0);

      drive(1'b0, INC, 3'd5, 32'h0, 3'd5, 3'd5);
      step();
      chk("d1_inc_cafe", a1, 32'h0000_CAFF);
      chk("d0_inc_reg5", b0, 32'h1);

      drive(1'b1, LOAD, 3'd4, 32'h0000_0099, 3'd4, 3'd5);
      step();
      chk("rst_beats_load", a0, 32'h0);
      chk("rst_restores_cafe", b1, 32'h0000_CAFE);
      chk("rst_reg5_d0", b0, 32'h0);

      drive(1'b0, LOAD, 3'd4, 32'h0000_0099, 3'd4, 3'd4);
      step();
      chk("load_reg4", a0, 32'h0000_0099);
      drive(1'b0, CLR, 3'd4, 32'h0, 3'd4, 3'd4);
      step();
      chk("clear_reg4", a0, 32'h0);
      chk("clear_zero", {31'b0, z0}, 32'h1);
      chk("clear_noerr", {31'b0, err0}, 32'h0);

      drive(1'b0, HOLD, 3'd0, 32'h0, 3'd1, 3'd2);
      step();
      @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
